axi_llc_scrub_sched: RTL and testbench
======================================

AXI_LLC_SCRUB_SCHED -- requirements
Module: axi_llc_scrub_sched

Interface
REQ-001 SHALL have parameter NumWays, default 8: number of data ways scrubbed.
REQ-002 SHALL have parameter NumGranules, default 4: ECC granules per way, minimum 1.
REQ-003 SHALL have parameter CntWidth, default 16: width of the interval and error counters.
REQ-004 SHALL have parameter RespWindow, default 8: cycles to wait for a scrub result, minimum 1.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (rising edge), then rst_i input 1 (asynchronous, active-high).
REQ-006 SHALL have enable_i, input, 1 bit: scrubbing enabled.
REQ-007 SHALL have interval_i, input, CntWidth bits: idle cycles between triggers.
REQ-008 SHALL have clear_i, input, 1 bit: synchronous clear of the error counters and pass counter.
REQ-009 SHALL have scrub_trigger_o, output, NumWays*NumGranules bits: one-hot trigger pulse at index way*NumGranules+granule.
REQ-010 SHALL have scrubber_fix_i, input, NumWays*NumGranules bits: corrected-error reports, same indexing.
REQ-011 SHALL have scrub_uncorrectable_i, input, NumWays*NumGranules bits: uncorrectable-error reports, same indexing.
REQ-012 SHALL have cur_way_o, output, idx_width(NumWays) bits: current target way.
REQ-013 SHALL have cur_granule_o, output, idx_width(NumGranules) bits: current target granule.
REQ-014 SHALL have fix_cnt_o, output, CntWidth bits: saturating count of corrected errors.
REQ-015 SHALL have uncorr_cnt_o, output, CntWidth bits: saturating count of uncorrectable errors.
REQ-016 SHALL have pass_done_o, output, 1 bit: one-cycle pulse when a full sweep completes.
REQ-017 SHALL have pass_cnt_o, output, CntWidth bits: wrapping count of completed sweeps.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT, TRIG and RESP.
REQ-019 SHALL transition IDLE->WAIT when enable_i=1 and load the interval counter with interval_i.
REQ-020 SHALL, in WAIT, decrement the interval counter each cycle and go to TRIG when it is 0; interval_i=0 gives TRIG on the next cycle.
REQ-021 SHALL, in TRIG, drive exactly one scrub_trigger_o bit high for exactly one cycle, then go to RESP with the window counter loaded to RespWindow-1.
REQ-022 SHALL, in RESP, sample only the target index of scrubber_fix_i and scrub_uncorrectable_i, and ignore all other bits.
REQ-023 SHALL increment fix_cnt_o by 1 per cycle its target bit is high and saturate at all-ones; uncorr_cnt_o behaves the same way.
REQ-024 SHALL leave RESP when the window counter reaches 0 or the first target report arrives, whichever comes first, and advance the pointer.
REQ-025 SHALL advance the pointer granule-first: granule+1, and on wrap granule=0 with way+1.
REQ-026 SHALL, on wrap from (NumWays-1, NumGranules-1) to (0,0), pulse pass_done_o for one cycle and increment pass_cnt_o modulo 2^CntWidth.
REQ-027 SHALL, after advancing, go to WAIT with the counter reloaded from interval_i if enable_i=1, else go to IDLE with the pointer kept.
REQ-028 SHALL, when enable_i deasserts in WAIT, go to IDLE next cycle without a trigger; in TRIG or RESP the current granule finishes first.
REQ-029 SHALL give clear_i priority over a same-cycle increment: the counters read 0 on the next cycle and the increment is lost.
REQ-030 SHALL sample interval_i only on counter load; changes mid-WAIT have no effect.
REQ-031 SHALL drive all outputs from registers, with no combinational input-to-output path.

Reset
REQ-032 SHALL, while rst_i=1, force state IDLE, scrub_trigger_o=0, cur_way_o=0, cur_granule_o=0, all counters 0 and pass_done_o=0, asynchronously.
REQ-033 SHALL restart from (0,0) with no trigger emitted on reset deassertion mid-RESP.

Structure
REQ-034 SHALL have the FSM enum scrub_state_e placed in axi_llc_pkg.
REQ-035 SHALL place the flat index helper (way*NumGranules+granule) in axi_llc_pkg.
REQ-036 SHALL use no sub-module; counters are inline.
REQ-037 SHALL use cf_math_pkg::idx_width for the pointer widths.

Verification
REQ-038 SHALL check: NumWays=2, NumGranules=2, interval_i=3, enable held, no errors -> trigger bits 0,1,2,3 in order, 4+1+RespWindow cycles apart; pass_done_o pulses once; pass_cnt_o=1.
REQ-039 SHALL check: scrubber_fix_i target bit high 2 cycles into RESP -> fix_cnt_o=1, early advance to the next granule.
REQ-040 SHALL check: non-target scrub_uncorrectable_i bit pulsed -> uncorr_cnt_o stays 0.
REQ-041 SHALL check: CntWidth=4, 20 fix reports -> fix_cnt_o saturates at 15; clear_i coincident with a report -> 0.
REQ-042 SHALL check: enable_i dropped mid-WAIT -> IDLE with no trigger; re-enabled -> the same pointer is triggered.
REQ-043 SHALL check: rst_i asserted mid-RESP -> all outputs 0 within the same cycle; after release the first trigger is index 0.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared types and helpers for the LLC scrub scheduler.
package axi_llc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TRIG = 2'd2,
        RESP = 2'd3
    } scrub_state_e;

    // Flat position of a (way, granule) pair in the trigger/report vectors.
    function automatic int unsigned flat_idx(input int unsigned way,
                                             input int unsigned granule,
                                             input int unsigned num_granules);
        return way * num_granules + granule;
    endfunction

endpackage

// File: rtl/cf_math_pkg.sv
// Small math helpers shared across the LLC blocks.
package cf_math_pkg;

    // Width of an index into num_idx items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/axi_llc_scrub_sched.sv
// Periodic ECC scrub scheduler: walks every (way, granule), fires a one-hot trigger,
// waits a bounded window for the result and keeps corrected/uncorrectable/sweep counters.
module axi_llc_scrub_sched
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumWays     = 8,
    parameter int unsigned NumGranules = 4,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned RespWindow  = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          enable_i,
    input  logic [CntWidth-1:0]                           interval_i,
    input  logic                                          clear_i,
    output logic [NumWays*NumGranules-1:0]                scrub_trigger_o,
    input  logic [NumWays*NumGranules-1:0]                scrubber_fix_i,
    input  logic [NumWays*NumGranules-1:0]                scrub_uncorrectable_i,
    output logic [cf_math_pkg::idx_width(NumWays)-1:0]     cur_way_o,
    output logic [cf_math_pkg::idx_width(NumGranules)-1:0] cur_granule_o,
    output logic [CntWidth-1:0]                           fix_cnt_o,
    output logic [CntWidth-1:0]                           uncorr_cnt_o,
    output logic                                          pass_done_o,
    output logic [CntWidth-1:0]                           pass_cnt_o
);

    localparam int unsigned NumIdx = NumWays * NumGranules;
    localparam int unsigned WayW   = cf_math_pkg::idx_width(NumWays);
    localparam int unsigned GranW  = cf_math_pkg::idx_width(NumGranules);
    localparam int unsigned IdxW   = cf_math_pkg::idx_width(NumIdx);
    localparam int unsigned WinW   = cf_math_pkg::idx_width(RespWindow);

    localparam logic [WayW-1:0]  LastWay  = WayW'(NumWays - 1);
    localparam logic [GranW-1:0] LastGran = GranW'(NumGranules - 1);
    localparam logic [WinW-1:0]  WinLoad  = WinW'(RespWindow - 1);

    scrub_state_e        state_q, state_d;
    logic [CntWidth-1:0] ivl_q, ivl_d;
    logic [WinW-1:0]     win_q, win_d;
    logic [WayW-1:0]     way_q, way_d;
    logic [GranW-1:0]    gran_q, gran_d;
    logic [NumIdx-1:0]   trig_q, trig_d;
    logic [CntWidth-1:0] fix_q, fix_d;
    logic [CntWidth-1:0] uncorr_q, uncorr_d;
    logic [CntWidth-1:0] pass_cnt_q, pass_cnt_d;
    logic                pass_done_q, pass_done_d;

    logic [IdxW-1:0] tgt_idx;
    logic            fix_hit;
    logic            uncorr_hit;

    // Only the bit of the granule under scrub is ever looked at.
    assign tgt_idx    = IdxW'(flat_idx(32'(way_q), 32'(gran_q), NumGranules));
    assign fix_hit    = (state_q == RESP) && scrubber_fix_i[tgt_idx];
    assign uncorr_hit = (state_q == RESP) && scrub_uncorrectable_i[tgt_idx];

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        state_d     = state_q;
        ivl_d       = ivl_q;
        win_d       = win_q;
        way_d       = way_q;
        gran_d      = gran_q;
        trig_d      = '0;
        pass_done_d = 1'b0;
        fix_d       = fix_q;
        uncorr_d    = uncorr_q;
        pass_cnt_d  = pass_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                    ivl_d   = interval_i;
                end
            end
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (ivl_q == '0) begin
                    state_d = TRIG;
                    trig_d  = NumIdx'(1) << tgt_idx;
                end else begin
                    ivl_d = ivl_q - CntWidth'(1);
                end
            end
            TRIG: begin
                state_d = RESP;
                win_d   = WinLoad;
            end
            RESP: begin
                if (win_q == '0 || fix_hit || uncorr_hit) begin
                    if (gran_q == LastGran) begin
                        gran_d = '0;
                        if (way_q == LastWay) begin
                            way_d       = '0;
                            pass_done_d = 1'b1;
                            pass_cnt_d  = pass_cnt_q + CntWidth'(1);
                        end else begin
                            way_d = way_q + WayW'(1);
                        end
                    end else begin
                        gran_d = gran_q + GranW'(1);
                    end
                    state_d = enable_i ? WAIT : IDLE;
                    ivl_d   = interval_i;
                end else begin
                    win_d = win_q - WinW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (fix_hit && fix_q != '1) begin
            fix_d = fix_q + CntWidth'(1);
        end
        if (uncorr_hit && uncorr_q != '1) begin
            uncorr_d = uncorr_q + CntWidth'(1);
        end
        // Clear wins over any same-cycle increment.
        if (clear_i) begin
            fix_d      = '0;
            uncorr_d   = '0;
            pass_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ivl_q       <= '0;
            win_q       <= '0;
            way_q       <= '0;
            gran_q      <= '0;
            trig_q      <= '0;
            fix_q       <= '0;
            uncorr_q    <= '0;
            pass_cnt_q  <= '0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ivl_q       <= ivl_d;
            win_q       <= win_d;
            way_q       <= way_d;
            gran_q      <= gran_d;
            trig_q      <= trig_d;
            fix_q       <= fix_d;
            uncorr_q    <= uncorr_d;
            pass_cnt_q  <= pass_cnt_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign scrub_trigger_o = trig_q;
    assign cur_way_o       = way_q;
    assign cur_granule_o   = gran_q;
    assign fix_cnt_o       = fix_q;
    assign uncorr_cnt_o    = uncorr_q;
    assign pass_done_o     = pass_done_q;
    assign pass_cnt_o      = pass_cnt_q;

endmodule

// File: tb/tb_axi_llc_scrub_sched.sv
// Directed bench for axi_llc_scrub_sched (2 ways x 2 granules, 4-bit counters, 4-cycle window).
module tb_axi_llc_scrub_sched;

    localparam int unsigned NW = 2;
    localparam int unsigned NG = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 4;
    localparam int unsigned NI = NW * NG;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic [CW-1:0] interval_i;
    logic          clear_i;
    logic [NI-1:0] scrub_trigger_o;
    logic [NI-1:0] scrubber_fix_i;
    logic [NI-1:0] scrub_uncorrectable_i;
    logic [0:0]    cur_way_o;
    logic [0:0]    cur_granule_o;
    logic [CW-1:0] fix_cnt_o;
    logic [CW-1:0] uncorr_cnt_o;
    logic          pass_done_o;
    logic [CW-1:0] pass_cnt_o;

    axi_llc_scrub_sched #(
        .NumWays    (NW),
        .NumGranules(NG),
        .CntWidth   (CW),
        .RespWindow (RW)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .enable_i             (enable_i),
        .interval_i           (interval_i),
        .clear_i              (clear_i),
        .scrub_trigger_o      (scrub_trigger_o),
        .scrubber_fix_i       (scrubber_fix_i),
        .scrub_uncorrectable_i(scrub_uncorrectable_i),
        .cur_way_o            (cur_way_o),
        .cur_granule_o        (cur_granule_o),
        .fix_cnt_o            (fix_cnt_o),
        .uncorr_cnt_o         (uncorr_cnt_o),
        .pass_done_o          (pass_done_o),
        .pass_cnt_o           (pass_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int idx;
        int gap;   // expected cycles since previous trigger, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks      = 0;
    int   n_errors      = 0;
    int   cyc           = 0;
    int   last_trig_cyc = 0;
    int   pass_pulses   = 0;

    // Reference model of the scrub pointer and sweep counters.
    int model_ptr      = 0;
    int model_passes   = 0;
    int model_pass_cnt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_trig(input int gap);
        exp_t e;
        e.idx = model_ptr;
        e.gap = gap;
        exp_q.push_back(e);
        if (model_ptr == NI - 1) begin
            model_passes++;
            model_pass_cnt = (model_pass_cnt + 1) % (1 << CW);
        end
        model_ptr = (model_ptr + 1) % NI;
    endtask

    function automatic int cur_ptr();
        return int'(cur_way_o) * NG + int'(cur_granule_o);
    endfunction

    task automatic wait_trig(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            if (scrub_trigger_o !== '0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every trigger the DUT presents is matched against the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        int   act_idx;
        if (pass_done_o === 1'b1) pass_pulses++;
        if (scrub_trigger_o !== '0) begin
            act_idx = -1;
            for (int i = 0; i < NI; i++) if (scrub_trigger_o[i]) act_idx = i;
            check("trig_onehot", $countones(scrub_trigger_o), 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_trigger: got index %0d, expected none (t=%0t)", act_idx, $time);
            end else begin
                e = exp_q.pop_front();
                check("trig_index", act_idx, e.idx);
                if (e.gap > 0) check("trig_gap", cyc - last_trig_cyc, e.gap);
            end
            last_trig_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        rst_i                 = 1'b1;
        enable_i              = 1'b0;
        clear_i               = 1'b0;
        interval_i            = '0;
        scrubber_fix_i        = '0;
        scrub_uncorrectable_i = '0;

        #1;
        check("rst_trigger", 32'(scrub_trigger_o), 0);
        check("rst_way", 32'(cur_way_o), 0);
        check("rst_granule", 32'(cur_granule_o), 0);
        check("rst_fix_cnt", 32'(fix_cnt_o), 0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt_o), 0);
        check("rst_pass_cnt", 32'(pass_cnt_o), 0);
        check("rst_pass_done", 32'(pass_done_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Full sweep, no errors: interval 3 gives 4 + 1 + RW cycles between triggers.
        interval_i = 4'd3;
        push_trig(0);
        repeat (3) push_trig(4 + 1 + RW);
        enable_i = 1'b1;
        repeat (4) wait_trig("sweep_trigger");
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("sweep_pass_pulses", pass_pulses, model_passes);
        check("sweep_pass_cnt", 32'(pass_cnt_o), model_pass_cnt);
        check("sweep_ptr", cur_ptr(), model_ptr);
        check("sweep_fix_cnt", 32'(fix_cnt_o), 0);

        // Target fix report two cycles into RESP ends the window early.
        interval_i = 4'd1;
        tgt = model_ptr;
        push_trig(0);
        enable_i = 1'b1;
        wait_trig("fix_trigger");
        @(negedge clk_i);
        @(negedge clk_i);
        scrubber_fix_i = NI'(1) << tgt;
        @(negedge clk_i);
        scrubber_fix_i = '0;
        enable_i       = 1'b0;
        check("fix_cnt_one", 32'(fix_cnt_o), 1);
        check("fix_early_advance", cur_ptr(), model_ptr);
        repeat (4) @(negedge clk_i);

        // Reports on non-target bits are ignored; the window times out.
        interval_i = 4'd0;
        tgt = model_ptr;
        push_trig(0);
        enable_i = 1'b1;
        wait_trig("nontarget_trigger");
        @(negedge clk_i);
        scrub_uncorrectable_i = ~(NI'(1) << tgt);
        scrubber_fix_i        = ~(NI'(1) << tgt);
        enable_i              = 1'b0;
        @(negedge clk_i);
        scrub_uncorrectable_i = '0;
        scrubber_fix_i        = '0;
        repeat (6) @(negedge clk_i);
        check("nontarget_uncorr_cnt", 32'(uncorr_cnt_o), 0);
        check("nontarget_fix_cnt", 32'(fix_cnt_o), 1);
        check("nontarget_ptr", cur_ptr(), model_ptr);

        // Twenty target fix reports saturate the 4-bit counter at 15.
        scrubber_fix_i = '1;
        repeat (20) push_trig(0);
        enable_i = 1'b1;
        repeat (20) wait_trig("sat_trigger");
        @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        scrubber_fix_i = '0;
        check("sat_fix_cnt", 32'(fix_cnt_o), 15);
        check("sat_ptr", cur_ptr(), model_ptr);
        check("sat_pass_cnt", 32'(pass_cnt_o), model_pass_cnt);

        // Clear coincident with a target report: the increment is lost.
        scrubber_fix_i = '1;
        push_trig(0);
        enable_i = 1'b1;
        wait_trig("clear_trigger");
        @(negedge clk_i);
        clear_i  = 1'b1;
        enable_i = 1'b0;
        @(negedge clk_i);
        clear_i        = 1'b0;
        scrubber_fix_i = '0;
        model_pass_cnt = 0;
        check("clear_fix_cnt", 32'(fix_cnt_o), 0);
        check("clear_pass_cnt", 32'(pass_cnt_o), 0);
        check("clear_ptr", cur_ptr(), model_ptr);

        // Target uncorrectable report counts once and wraps the sweep.
        scrub_uncorrectable_i = '1;
        push_trig(0);
        enable_i = 1'b1;
        wait_trig("uncorr_trigger");
        @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        scrub_uncorrectable_i = '0;
        repeat (2) @(negedge clk_i);
        check("uncorr_cnt_one", 32'(uncorr_cnt_o), 1);
        check("uncorr_fix_cnt", 32'(fix_cnt_o), 0);
        check("uncorr_pass_cnt", 32'(pass_cnt_o), model_pass_cnt);
        check("uncorr_ptr", cur_ptr(), model_ptr);

        // Enable dropped mid-WAIT: no trigger, pointer kept, re-enable resumes it.
        interval_i = 4'd5;
        enable_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        enable_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("wait_drop_ptr", cur_ptr(), model_ptr);
        push_trig(0);
        push_trig(0);
        enable_i = 1'b1;
        wait_trig("reenable_trigger");
        wait_trig("reenable_next_trigger");

        // Reset in the middle of RESP clears everything asynchronously.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        model_ptr      = 0;
        model_pass_cnt = 0;
        check("midresp_rst_trigger", 32'(scrub_trigger_o), 0);
        check("midresp_rst_way", 32'(cur_way_o), 0);
        check("midresp_rst_granule", 32'(cur_granule_o), 0);
        check("midresp_rst_uncorr_cnt", 32'(uncorr_cnt_o), 0);
        check("midresp_rst_fix_cnt", 32'(fix_cnt_o), 0);
        check("midresp_rst_pass_cnt", 32'(pass_cnt_o), 0);
        check("midresp_rst_pass_done", 32'(pass_done_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        push_trig(0);
        wait_trig("post_reset_trigger");
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (8) @(negedge clk_i);

        check("total_pass_pulses", pass_pulses, model_passes);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
